// File: rtl/sd_pkg.sv
// Shared constants for the SPI-mode SD card model: command indices, R1 bit
// positions, OCR values and the responder state encoding.
package sd_pkg;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] CMD58  = 6'd58;
  localparam logic [5:0] ACMD41 = 6'd41;

  localparam int R1_IDLE    = 0;
  localparam int R1_ILLEGAL = 2;
  localparam int R1_CRC     = 3;

  // Bit 30 is CCS and bit 31 is the power-up-done (busy) flag.
  localparam logic [31:0] OCR_IDLE  = 32'h40FF_8000;
  localparam logic [31:0] OCR_READY = 32'hC0FF_8000;

  typedef enum logic [2:0] {
    DESELECTED,
    HUNT,
    RX_CMD,
    NCR,
    TX_RESP
  } sd_state_e;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB first. A clear together with an enable
// restarts the CRC from zero and absorbs din in the same cycle.
module sd_crc7 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] base;
  logic [6:0] nxt;

  always_comb begin
    base = clr ? 7'h00 : crc;
    nxt  = {base[5:0], 1'b0} ^ ((din ^ base[6]) ? 7'h09 : 7'h00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 7'h00;
    end else if (en) begin
      crc <= nxt;
    end else if (clr) begin
      crc <= 7'h00;
    end
  end

endmodule

// File: rtl/sd_card_responder.sv
// SPI-mode SD card model answering CMD0/CMD8/CMD55/ACMD41/CMD58 with R1/R3/R7.
// Define SD_RESPONDER_CRC_CHECK_EN to verify the CRC7 field of each command.
module sd_card_responder
  import sd_pkg::*;
#(
  parameter int INIT_ACMD41_COUNT = 2,
  parameter int NCR_BYTES         = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        spi_clk,
  input  logic        mosi,
  output logic        miso,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        card_ready
);

  // cmd_valid is a one-clk pulse with no ready: cmd_index/cmd_arg update in
  // the same cycle and hold until the next accepted frame.
  localparam logic [3:0] INIT_CNT = 4'(INIT_ACMD41_COUNT);
  localparam logic [6:0] NCR_BITS = 7'(8 * NCR_BYTES);

  logic [1:0] cs_sync, sclk_sync, mosi_sync;
  logic       sclk_d;
  logic       cs_s, mosi_s, sclk_rise, sclk_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync   <= 2'b11;
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b11;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], cs};
      sclk_sync <= {sclk_sync[0], spi_clk};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_d    <= sclk_sync[1];
    end
  end

  assign cs_s      = cs_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[1] & sclk_d;

  sd_state_e   state;
  logic [5:0]  bit_cnt;
  logic [46:0] shift;
  logic [47:0] frame;
  logic [39:0] resp_sr;
  logic [5:0]  resp_left;
  logic [6:0]  ncr_left;
  logic        idle_flag, app_flag;
  logic [3:0]  acmd_cnt;

  // The frame as it stands once the bit currently being sampled is included.
  assign frame = {shift, mosi_s};

  logic [5:0]  idx;
  logic [31:0] arg;
  logic        frame_ok, crc_ok;
  logic        idle_n, ready_n, app_n, illegal, long_resp;
  logic [3:0]  cnt_n, cnt_inc;
  logic [31:0] tail;
  logic [7:0]  r1;

  always_comb begin
    idx       = frame[45:40];
    arg       = frame[39:8];
    frame_ok  = ~frame[47] & frame[46] & frame[0];
    idle_n    = idle_flag;
    ready_n   = card_ready;
    app_n     = 1'b0;
    cnt_n     = acmd_cnt;
    cnt_inc   = (acmd_cnt == 4'd15) ? 4'd15 : acmd_cnt + 4'd1;
    illegal   = 1'b0;
    long_resp = 1'b0;
    tail      = 32'h0;
    if (idx == CMD0) begin
      idle_n  = 1'b1;
      ready_n = 1'b0;
      cnt_n   = 4'd0;
    end else if (idx == CMD8) begin
      long_resp = 1'b1;
      tail      = {20'h0, arg[11:8], arg[7:0]};
    end else if (idx == CMD55) begin
      app_n = 1'b1;
    end else if (idx == ACMD41 && app_flag) begin
      cnt_n = cnt_inc;
      if (cnt_inc >= INIT_CNT) begin
        idle_n  = 1'b0;
        ready_n = 1'b1;
      end
    end else if (idx == CMD58) begin
      long_resp = 1'b1;
      tail      = card_ready ? OCR_READY : OCR_IDLE;
    end else begin
      illegal = 1'b1;
    end
    r1             = 8'h00;
    r1[R1_IDLE]    = idle_n;
    r1[R1_ILLEGAL] = illegal;
  end

`ifdef SD_RESPONDER_CRC_CHECK_EN
  logic [6:0] crc_val;
  logic       crc_clr, crc_en;
  logic [7:0] crc_r1;

  // The start bit is absorbed in HUNT, the remaining 39 CRC'd bits in RX_CMD.
  assign crc_clr = (state != RX_CMD);
  assign crc_en  = sclk_rise & ~cs_s &
                   ((state == HUNT && !mosi_s) || (state == RX_CMD && bit_cnt < 6'd40));

  sd_crc7 u_crc7 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (mosi_s),
    .crc   (crc_val)
  );

  assign crc_ok = (frame[7:1] == crc_val);

  always_comb begin
    crc_r1          = 8'h00;
    crc_r1[R1_CRC]  = 1'b1;
    crc_r1[R1_IDLE] = idle_flag;
  end
`else
  logic unused_crc_field;
  assign unused_crc_field = ^frame[7:1];
  assign crc_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= DESELECTED;
      bit_cnt    <= 6'd0;
      shift      <= 47'h0;
      resp_sr    <= 40'h0;
      resp_left  <= 6'd0;
      ncr_left   <= 7'd0;
      miso       <= 1'b1;
      cmd_valid  <= 1'b0;
      cmd_index  <= 6'd0;
      cmd_arg    <= 32'h0;
      card_ready <= 1'b0;
      idle_flag  <= 1'b1;
      app_flag   <= 1'b0;
      acmd_cnt   <= 4'd0;
    end else begin
      cmd_valid <= 1'b0;
      if (cs_s) begin
        state <= DESELECTED;
        miso  <= 1'b1;
      end else begin
        case (state)
          DESELECTED: state <= HUNT;
          HUNT: begin
            if (sclk_fall) miso <= 1'b1;
            if (sclk_rise && !mosi_s) begin
              state   <= RX_CMD;
              bit_cnt <= 6'd1;
              shift   <= {shift[45:0], 1'b0};
            end
          end
          RX_CMD: begin
            if (sclk_fall) miso <= 1'b1;
            if (sclk_rise) begin
              shift   <= {shift[45:0], mosi_s};
              bit_cnt <= bit_cnt + 6'd1;
              if (bit_cnt == 6'd47) begin
                if (!frame_ok) begin
                  state <= HUNT;
                end else begin
                  state    <= NCR;
                  ncr_left <= NCR_BITS;
                  if (crc_ok) begin
                    cmd_valid  <= 1'b1;
                    cmd_index  <= idx;
                    cmd_arg    <= arg;
                    idle_flag  <= idle_n;
                    card_ready <= ready_n;
                    app_flag   <= app_n;
                    acmd_cnt   <= cnt_n;
                    resp_sr    <= long_resp ? {r1, tail} : {r1, 32'h0};
                    resp_left  <= long_resp ? 6'd40 : 6'd8;
                  end else begin
`ifdef SD_RESPONDER_CRC_CHECK_EN
                    resp_sr   <= {crc_r1, 32'h0};
`else
                    resp_sr   <= 40'h0;
`endif
                    resp_left <= 6'd8;
                  end
                end
              end
            end
          end
          NCR: begin
            if (sclk_fall) begin
              miso     <= 1'b1;
              ncr_left <= ncr_left - 7'd1;
              if (ncr_left == 7'd1) state <= TX_RESP;
            end
          end
          TX_RESP: begin
            if (sclk_fall && resp_left != 6'd0) begin
              miso      <= resp_sr[39];
              resp_sr   <= {resp_sr[38:0], 1'b0};
              resp_left <= resp_left - 6'd1;
            end
            // Leave on the edge that samples the last bit so a frame may follow with no gap.
            if (sclk_rise && resp_left == 6'd0) state <= HUNT;
          end
          default: state <= DESELECTED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_card_responder.sv
// Directed bench for sd_card_responder: expected responses and accepted
// commands are queued by the driver and checked by independent monitors.
module tb_sd_card_responder;

  localparam int INIT_CNT = 2;
  localparam int NCR      = 1;
  localparam int HALF     = 60;

  logic        clk = 1'b0;
  logic        rst_n, cs, spi_clk, mosi;
  logic        miso, cmd_valid, card_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;

  // [47:40] response length in bytes, [39:0] response right-aligned
  logic [47:0] exp_q[$];
  // {index, argument} of each frame expected to raise cmd_valid
  logic [37:0] vld_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int ones_since_cmd = 0;

  sd_card_responder #(.INIT_ACMD41_COUNT(INIT_CNT), .NCR_BYTES(NCR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs         (cs),
    .spi_clk    (spi_clk),
    .mosi       (mosi),
    .miso       (miso),
    .cmd_valid  (cmd_valid),
    .cmd_index  (cmd_index),
    .cmd_arg    (cmd_arg),
    .card_ready (card_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic fb;
    c = 7'h0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // driver tasks
  task automatic spi_bit(input logic b);
    mosi = b;
    #HALF spi_clk = 1'b1;
    #HALF spi_clk = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] f, input int n_fill);
    for (int i = 47; i >= 0; i--) spi_bit(f[i]);
    ones_since_cmd = 0;
    for (int i = 0; i < n_fill * 8; i++) spi_bit(1'b1);
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg,
                       input int len, input logic [39:0] resp, input logic vld);
    logic [39:0] body;
    body = {2'b01, idx, arg};
    exp_q.push_back({8'(len), resp});
    if (vld) vld_q.push_back({idx, arg});
    send_frame({body, crc7(body), 1'b1}, NCR + len);
  endtask

  task automatic select(input logic level);
    cs = level;
    #300;
  endtask

  // response monitor: assembles miso bytes starting at the first 0 bit
  initial begin
    logic        collecting;
    int          bits_left;
    logic [39:0] acc;
    logic [47:0] cur;
    collecting = 1'b0;
    bits_left  = 0;
    acc        = 40'h0;
    cur        = 48'h0;
    forever begin
      @(posedge spi_clk);
      if (rst_n === 1'b1 && cs === 1'b0) begin
        if (!collecting) begin
          if (miso === 1'b1) ones_since_cmd++;
          else if (exp_q.size() == 0) check("unexpected_resp", {63'h0, miso}, 64'h1);
          else begin
            cur = exp_q.pop_front();
            check("ncr_filler_bits", 64'(ones_since_cmd), 64'(NCR * 8));
            collecting = 1'b1;
            acc        = 40'h0;
            bits_left  = int'(cur[47:40]) * 8 - 1;
          end
        end else begin
          acc = {acc[38:0], miso};
          bits_left--;
          if (bits_left == 0) begin
            collecting = 1'b0;
            ones_since_cmd = 0;
            check("response", 64'(acc), 64'(cur[39:0]));
          end
        end
      end
    end
  end

  // command monitor: each cmd_valid pulse must match the next queued frame
  initial begin
    logic [37:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && cmd_valid === 1'b1) begin
        if (vld_q.size() == 0) check("unexpected_cmd_valid", {58'h0, cmd_index}, 64'hFF);
        else begin
          e = vld_q.pop_front();
          check("cmd_index", 64'(cmd_index), 64'(e[37:32]));
          check("cmd_arg", 64'(cmd_arg), 64'(e[31:0]));
        end
        @(negedge clk);
        check("cmd_valid_width", 64'(cmd_valid), 64'h0);
      end
    end
  end

  initial begin
    logic [47:0] f;
    rst_n = 1'b0; cs = 1'b1; spi_clk = 1'b0; mosi = 1'b1;
    #102 rst_n = 1'b1;
    #20;
    check("reset_miso", 64'(miso), 64'h1);
    check("reset_cmd_valid", 64'(cmd_valid), 64'h0);
    check("reset_cmd_index", 64'(cmd_index), 64'h0);
    check("reset_cmd_arg", 64'(cmd_arg), 64'h0);
    check("reset_card_ready", 64'(card_ready), 64'h0);

    select(1'b0);
    issue(6'd0,  32'h0,        1, 40'h01, 1'b1);
    issue(6'd8,  32'h0000_01AA, 5, 40'h01_0000_01AA, 1'b1);
    issue(6'd58, 32'h0,        5, 40'h01_40FF_8000, 1'b1);
    issue(6'd5,  32'h0,        1, 40'h05, 1'b1);
    issue(6'd41, 32'h4000_0000, 1, 40'h05, 1'b1);
    issue(6'd55, 32'h0,        1, 40'h01, 1'b1);
    issue(6'd41, 32'h4000_0000, 1, 40'h01, 1'b1);
    check("ready_after_first_acmd41", 64'(card_ready), 64'h0);
    issue(6'd55, 32'h0,        1, 40'h01, 1'b1);
    issue(6'd41, 32'h4000_0000, 1, 40'h00, 1'b1);
    check("ready_after_second_acmd41", 64'(card_ready), 64'h1);
    issue(6'd58, 32'h0,        5, 40'h00_C0FF_8000, 1'b1);
    issue(6'd55, 32'h0,        1, 40'h00, 1'b1);
    issue(6'd8,  32'h0000_02A5, 5, 40'h00_0000_02A5, 1'b1);

    // 20 bits of CMD8, then deselect: the partial frame must vanish
    f = {2'b01, 6'd8, 32'h0000_01AA, 7'h43, 1'b1};
    for (int i = 47; i >= 28; i--) spi_bit(f[i]);
    select(1'b1);
    select(1'b0);
    issue(6'd0, 32'h0, 1, 40'h01, 1'b1);
    check("ready_after_cmd0", 64'(card_ready), 64'h0);

    // bad transmission bit, then bad end bit: both dropped silently
    send_frame(48'h00_0000_0000_01, 2);
    send_frame(48'h40_0000_0000_94, 2);
    issue(6'd55, 32'h0,        1, 40'h01, 1'b1);
    issue(6'd41, 32'h4000_0000, 1, 40'h01, 1'b1);
    issue(6'd55, 32'h0,        1, 40'h01, 1'b1);
    issue(6'd41, 32'h4000_0000, 1, 40'h00, 1'b1);
    check("ready_second_init", 64'(card_ready), 64'h1);

    // reset in the middle of a frame behaves like CMD0
    for (int i = 47; i >= 28; i--) spi_bit(f[i]);
    rst_n = 1'b0;
    #2;
    check("midreset_card_ready", 64'(card_ready), 64'h0);
    check("midreset_miso", 64'(miso), 64'h1);
    check("midreset_cmd_index", 64'(cmd_index), 64'h0);
    #50 rst_n = 1'b1;
    #300;
    issue(6'd58, 32'h0,        5, 40'h01_40FF_8000, 1'b1);
    issue(6'd55, 32'h0,        1, 40'h01, 1'b1);
    issue(6'd41, 32'h4000_0000, 1, 40'h01, 1'b1);

`ifdef SD_RESPONDER_CRC_CHECK_EN
    exp_q.push_back({8'd1, 40'h09});
    send_frame(48'h40_0000_0000_97, NCR + 1);
    check("ready_after_bad_crc", 64'(card_ready), 64'h0);
`endif

    for (int i = 0; i < 16; i++) spi_bit(1'b1);
    select(1'b1);
    check("responses_pending", 64'(exp_q.size()), 64'h0);
    check("cmd_valid_pending", 64'(vld_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sd_card_responder.md
# sd_card_responder

SPI-mode SD card target that answers the command stream produced by the host-side SD controller. It decodes 48-bit command frames on `mosi` and returns R1, R3 or R7 responses on `miso`. It models the idle/ready initialization sequence: CMD0, CMD8, CMD55/ACMD41 polling, then CMD58. It is used as an on-chip card model for bring-up and as the DUT partner in controller regression benches. Sector data transfer is out of scope.

## Interface
- `INIT_ACMD41_COUNT`, default 2: number of ACMD41 commands that must be received before the card leaves idle (1..15).
- `NCR_BYTES`, default 1: number of 0xFF filler bytes between the command end bit and the first response byte (1..8).
- `clk` input 1: system clock. It must run at least 8x `spi_clk`.
- `rst_n` input 1: asynchronous, active-low reset.
- `cs` input 1: chip select, active low, asynchronous to `clk`.
- `spi_clk` input 1: SPI clock, mode 0, asynchronous to `clk`.
- `mosi` input 1: host-to-card data.
- `miso` output 1: card-to-host data. Reset value 1.
- `cmd_valid` output 1: one-`clk` pulse per accepted frame. Reset value 0.
- `cmd_index` output 6: index of the last accepted command. Reset value 0.
- `cmd_arg` output 32: argument of the last accepted command. Reset value 0.
- `card_ready` output 1: high once initialization is complete. Reset value 0.

## Operation
- Input handling:
  - `cs`, `spi_clk` and `mosi` pass through 2-flop synchronizers.
  - A rising edge of `spi_clk` samples `mosi`.
  - A falling edge of `spi_clk` shifts `miso`.
- State machine states: DESELECTED, HUNT, RX_CMD, NCR, TX_RESP.
- State transitions:
  - DESELECTED -> HUNT when `cs` is low.
  - HUNT -> RX_CMD on the first sampled 0 bit. The search is bit-level and needs no byte alignment.
  - RX_CMD collects 48 bits, including the start bit, then checks the transmission bit (must be 1) and the end bit (must be 1).
  - Bad framing: drop the frame with no response and return to HUNT.
  - Good framing: pulse `cmd_valid`, latch `cmd_index` and `cmd_arg`, build the response, go to NCR.
  - NCR shifts out `NCR_BYTES`×0xFF, then goes to TX_RESP.
  - TX_RESP shifts the response MSB-first, then returns to HUNT.
  - `cs` high in any state: abort to DESELECTED and drive `miso` to 1. The partial frame is discarded. The idle flag, app flag and ACMD41 count are retained.
- R1 bits: [0] idle, [2] illegal command, [3] CRC error. All other bits are 0.
- Responses by command:
  - CMD0: R1. Sets idle, clears `card_ready`, clears the ACMD41 counter, clears the app flag.
  - CMD8: R7 = R1, then 0x00, 0x00, then `{4'h0, arg[11:8]}`, then `arg[7:0]` (echo of the check pattern).
  - CMD55: R1. Sets the app flag for the next frame only.
  - ACMD41 (CMD41 with the app flag set): increments the counter, saturating at 15. When the counter reaches `INIT_ACMD41_COUNT`, clear idle and set `card_ready`. R1 reflects the updated idle bit.
  - CMD58: R3 = R1, then the OCR in 4 bytes. OCR = 0x40FF8000 before ready and 0xC0FF8000 once ready (CCS=1, busy=1).
  - Any other index, or CMD41 without the app flag: R1 with the illegal bit set. The app flag clears.
- Every command other than CMD55 clears the app flag.

## Timing
- `cmd_valid` fires 3–5 `clk` after the synchronized rising edge that samples the end bit. It is exactly one cycle wide.
- `miso` for response bit n changes within 4 `clk` of the synchronized falling `spi_clk` edge that precedes its sampling edge.
- The first response byte starts exactly `NCR_BYTES`×8 `spi_clk` cycles after the end bit.
- A host that keeps clocking after the response sees 0xFF because HUNT drives 1. Back-to-back frames with no gap are accepted.
- Reset asserted mid-frame has the same effect as CMD0, and all outputs return to their reset values immediately.

## Configuration
- `SD_RESPONDER_CRC_CHECK_EN` defined:
  - CRC7 (polynomial x^7+x^3+1) is computed over the first 40 bits and compared with bits [7:1].
  - On mismatch: respond R1 with the CRC bit set plus the current idle bit. No state change occurs and `cmd_valid` stays low.
- `SD_RESPONDER_CRC_CHECK_EN` undefined: the CRC field is ignored and no CRC logic is instantiated.

## Structure
- Package `sd_pkg` holds:
  - command index constants CMD0/CMD8/CMD55/CMD58/ACMD41;
  - R1 bit positions;
  - OCR constants;
  - the state enum.
- Sub-module `sd_crc7` is a serial CRC7 unit (clear, bit-enable, data in, 7-bit CRC out). It is instantiated only under the macro and is reused by the host side.

## Test plan
- Reset, then `cs` low, then 40 00 00 00 00 95 -> one 0xFF, then R1 0x01, then `miso` held at 1. `cmd_valid` pulses once with `cmd_index`=0.
- CMD8 48 00 00 01 AA 87 -> 01 00 00 01 AA.
- With `INIT_ACMD41_COUNT`=2, send CMD55/ACMD41 (arg 0x40000000) twice -> 0x01 then 0x00. `card_ready` rises after the second ACMD41.
- CMD58 before ready -> 01 40 FF 80 00. CMD58 after ready -> 00 C0 FF 80 00.
- Undefined CMD5 while idle -> 0x05. CMD41 without a preceding CMD55 -> 0x05.
- `cs` high after 20 bits of CMD8, then a full CMD0 -> no response for the aborted frame, 0x01 for CMD0.
- With the macro defined, CMD0 with CRC byte 0x97 -> 0x09 and no `cmd_valid`.
